c2c_master_adapter: RTL and testbench
=====================================

# c2c_master_adapter

Master-side PHY adapter for the chip-to-chip link; it is the peer of the slave adapter on the far end. It sits between the C2C master IP and the MGT. It owns link bring-up: it issues the link-reset command pattern, then waits for receiver alignment and declares the link up. It also schedules clock-correction (CC) insertion on TX, strips CC and command symbols on RX, and re-issues link reset when alignment is lost or software requests it.

## Interface
- CC_PERIOD, 5000: cycles between CC requests; ≥ 2.
- LRST_LEN, 16: cycles the link-reset pattern is transmitted.
- HOLDOFF_LEN, 1200: cycles of zero idle after the link-reset pattern; exceeds the slave's 1000-cycle reset hold.
- ALIGN_STABLE, 256: consecutive `rx_aligned` cycles required before declaring link up.
- ALIGN_TIMEOUT, 65535: maximum cycles spent in WAIT_ALIGN before retrying.

- `c2c_phy_clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `c2c_tx_tdata` in 32: TX data from the C2C master.
- `c2c_tx_tvalid` in 1: TX data valid.
- `c2c_rx_data` out 32: RX data to the C2C master.
- `c2c_rx_valid` out 1: RX data valid.
- `mgt_rx_data` in 32, `mgt_rx_k` in 4: MGT receive word and K flags.
- `rx_aligned` in 1: MGT comma/byte alignment achieved.
- `mgt_tx_data` out 32, `mgt_tx_k` out 4: MGT transmit word and K flags.
- `link_reset_req` in 1: software link-reset request; level or pulse.
- `link_up` out 1: high while in state UP.
- `lrst_count` out 16: number of link resets issued; saturates at 0xFFFF.

## Operation
- FSM states: RESET_TX → HOLDOFF → WAIT_ALIGN → UP.
  - `rst` forces RESET_TX, so a link reset is always issued at startup.
- RESET_TX:
  - Transmit 0xFCFCFCFC with K=1111 for exactly LRST_LEN cycles, then go to HOLDOFF.
  - `lrst_count` increments once on entry.
  - `link_reset_req` is ignored in this state; the pattern is not restarted.
- HOLDOFF:
  - Transmit zeros with K=0000, except that a pending CC may be inserted.
  - After HOLDOFF_LEN cycles, go to WAIT_ALIGN.
- WAIT_ALIGN:
  - TX passes through as in UP.
  - An alignment counter counts consecutive `rx_aligned` cycles and clears when `rx_aligned` is low.
  - Reaching ALIGN_STABLE → UP.
  - ALIGN_TIMEOUT cycles without reaching it → RESET_TX.
- UP:
  - `rx_aligned` low for any single cycle → RESET_TX.
  - `link_reset_req` → RESET_TX.
- `link_reset_req` in HOLDOFF or WAIT_ALIGN → RESET_TX.
  - Exception: if the alignment counter reaches ALIGN_STABLE in the same cycle, the request still wins.
- CC scheduling:
  - A free-running down-counter expires every CC_PERIOD cycles and sets `cc_pending`.
  - Expiry while CC is already pending has no additional effect.
  - The counter runs in every state.
- TX mux, in priority order:
  1. RESET_TX → link-reset pattern.
  2. `cc_pending` and interruptible → CC word 0x000050BC, K=0001; clear `cc_pending`.
     - Interruptible means `c2c_tx_tvalid`=0, or the TX data is 0x001011BC, 0x001011FC or 0.
  3. `c2c_tx_tvalid`=1 → `c2c_tx_tdata`, K=0000.
  4. Otherwise → zero, K=0000.
- In HOLDOFF, `c2c_tx_tdata` is not forwarded; only zero or CC is sent.
- RX path:
  - CC word (0x000050BC / K=0001) or link-reset word (0xFCFCFCFC / K=1111) → data 0, valid 0.
  - Otherwise → data = `mgt_rx_data`; valid = `rx_aligned` and state ∈ {WAIT_ALIGN, UP}.

## Timing
- All outputs are registered with 1-cycle latency from inputs.
- Reset values: all data, K and valid outputs 0; `link_up` 0; `lrst_count` 0; `cc_pending` 0; CC counter reloaded to CC_PERIOD−1.
- In the first cycle after `rst` falls, `mgt_tx_data`=0xFCFCFCFC.
- State transitions are registered; the new state's TX output appears on the following cycle.
- `link_up` asserts in the cycle after the ALIGN_STABLE-th consecutive aligned cycle.
- `link_up` deasserts the cycle after the `rx_aligned` drop is sampled.
- A CC delayed by non-interruptible data is sent at the first interruptible cycle.
- CC delay is unbounded only if the C2C master never idles; this is accepted.

## Structure
- Constants in the shared package `c2c_pkg`: CLKC_D/K, LRST_D/K, ZERO_D/K, SPATD0/1/2, and the state enum `c2c_mstate_t`.
  - The slave adapter is migrated onto the same package.
- One sub-module, `c2c_cc_scheduler`:
  - Contains the CC_PERIOD counter, `cc_pending`, and the interruptible check.
  - Outputs `insert_cc`; takes `inhibit` (high in RESET_TX).

## Test plan
- Reset release → `mgt_tx_data`=0xFCFCFCFC, K=1111 for exactly 16 cycles, then zeros for 1200 cycles; `lrst_count`=1.
- `rx_aligned` held high from WAIT_ALIGN entry → `link_up`=1 after 256 cycles; non-CC RX words appear on `c2c_rx_data` 1 cycle later with `c2c_rx_valid`=1.
- RX word 0x000050BC with K=0001 in UP → `c2c_rx_valid`=0 and `c2c_rx_data`=0 for that cycle only.
- TX held valid at 0xDEADBEEF across CC expiry, then 0x001011BC → CC emitted in place of 0x001011BC, none earlier; one CC per expiry.
- In UP, drop `rx_aligned` for 1 cycle → `link_up`=0 next cycle, link-reset pattern follows, `lrst_count`=2.
- `rx_aligned` never asserted → link-reset pattern repeats every 16+1200+65535 cycles; `link_reset_req` pulsed during RESET_TX does not extend it.

Source files
------------

// File: rtl/c2c_pkg.sv
// c2c_pkg: symbols and types shared by the master and slave C2C PHY adapters.
//   CLKC_*  : clock-correction word and K flags
//   LRST_*  : link-reset command word and K flags
//   ZERO_*  : idle word and K flags
//   SPATD0/1/2 : TX words that may be replaced by a pending CC
//   c2c_mstate_t : master adapter link state
package c2c_pkg;

  localparam logic [31:0] CLKC_D = 32'h0000_50BC;
  localparam logic [3:0]  CLKC_K = 4'b0001;
  localparam logic [31:0] LRST_D = 32'hFCFC_FCFC;
  localparam logic [3:0]  LRST_K = 4'b1111;
  localparam logic [31:0] ZERO_D = 32'h0000_0000;
  localparam logic [3:0]  ZERO_K = 4'b0000;
  localparam logic [31:0] SPATD0 = 32'h0010_11BC;
  localparam logic [31:0] SPATD1 = 32'h0010_11FC;
  localparam logic [31:0] SPATD2 = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RESET_TX   = 2'd0,
    ST_HOLDOFF    = 2'd1,
    ST_WAIT_ALIGN = 2'd2,
    ST_UP         = 2'd3
  } c2c_mstate_t;

  // A CC may displace the current TX beat when the master is idle or is
  // sending one of the filler patterns.
  function automatic logic cc_interruptible(input logic valid, input logic [31:0] data);
    return !valid || (data == SPATD0) || (data == SPATD1) || (data == SPATD2);
  endfunction

endpackage

// File: rtl/c2c_cc_scheduler.sv
// c2c_cc_scheduler: free-running CC period counter plus pending flag.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_inhibit          : suppress insertion (link-reset pattern on the wire)
//   i_tx_valid/i_tx_data : beat currently offered to the TX mux
//   o_insert_cc        : replace this beat with the CC word
module c2c_cc_scheduler
  import c2c_pkg::*;
#(
  parameter int CC_PERIOD = 5000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inhibit,
  input  logic        i_tx_valid,
  input  logic [31:0] i_tx_data,
  output logic        o_insert_cc
);

  localparam int            CW     = $clog2(CC_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(CC_PERIOD - 1);

  logic [CW-1:0] r_cc_cnt;
  logic          r_cc_pend;
  logic          w_expire;

  assign w_expire    = (r_cc_cnt == '0);
  assign o_insert_cc = r_cc_pend && !i_inhibit && cc_interruptible(i_tx_valid, i_tx_data);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cc_cnt  <= RELOAD;
      r_cc_pend <= 1'b0;
    end else begin
      r_cc_cnt  <= w_expire ? RELOAD : r_cc_cnt - 1'b1;
      // a new expiry re-arms even if the old request leaves this cycle
      r_cc_pend <= w_expire || (r_cc_pend && !o_insert_cc);
    end
  end

endmodule

// File: rtl/c2c_master_adapter.sv
// c2c_master_adapter: master-side PHY adapter for the chip-to-chip link.
// Brings the link up (link-reset pattern, holdoff, alignment wait), inserts
// clock correction on TX and strips CC / link-reset words on RX.
//   i_c2c_phy_clk, i_rst            : clock, synchronous active-high reset
//   i_c2c_tx_tdata/tvalid           : TX beat from the C2C master
//   o_c2c_rx_data/valid             : RX beat to the C2C master
//   i_mgt_rx_data/k, i_rx_aligned   : MGT receive side
//   o_mgt_tx_data/k                 : MGT transmit side
//   i_link_reset_req                : software link reset (level or pulse)
//   o_link_up, o_lrst_count         : link status, saturating reset count
//
// state         | meaning
// ST_RESET_TX   | sending link-reset pattern for LRST_LEN cycles
// ST_HOLDOFF    | idle (zero or CC) for HOLDOFF_LEN cycles while the peer resets
// ST_WAIT_ALIGN | traffic flows; waiting ALIGN_STABLE aligned cycles or timeout
// ST_UP         | link up; any alignment loss or request re-issues link reset
module c2c_master_adapter
  import c2c_pkg::*;
#(
  parameter int CC_PERIOD     = 5000,
  parameter int LRST_LEN      = 16,
  parameter int HOLDOFF_LEN   = 1200,
  parameter int ALIGN_STABLE  = 256,
  parameter int ALIGN_TIMEOUT = 65535
) (
  input  logic        i_c2c_phy_clk,
  input  logic        i_rst,
  input  logic [31:0] i_c2c_tx_tdata,
  input  logic        i_c2c_tx_tvalid,
  output logic [31:0] o_c2c_rx_data,
  output logic        o_c2c_rx_valid,
  input  logic [31:0] i_mgt_rx_data,
  input  logic [3:0]  i_mgt_rx_k,
  input  logic        i_rx_aligned,
  output logic [31:0] o_mgt_tx_data,
  output logic [3:0]  o_mgt_tx_k,
  input  logic        i_link_reset_req,
  output logic        o_link_up,
  output logic [15:0] o_lrst_count
);

  localparam int            TW     = 17;
  localparam logic [TW-1:0] T_LRST = TW'(LRST_LEN - 1);
  localparam logic [TW-1:0] T_HOLD = TW'(HOLDOFF_LEN - 1);
  localparam logic [TW-1:0] T_TOUT = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [15:0]   A_LAST = 16'(ALIGN_STABLE - 1);

  c2c_mstate_t   r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [15:0]   r_align_cnt;
  logic          w_align_hit;
  logic          w_insert_cc;
  logic          w_tx_valid_eff;
  logic [31:0]   w_tx_d, w_rx_d;
  logic [3:0]    w_tx_k;
  logic          w_rx_v, w_rx_special;

  assign w_align_hit = i_rx_aligned && (r_align_cnt == A_LAST);

  // HOLDOFF never forwards master data, so the beat on offer there is idle
  // and a pending CC can always go out.
  assign w_tx_valid_eff = i_c2c_tx_tvalid && (r_state != ST_HOLDOFF);

  c2c_cc_scheduler #(.CC_PERIOD(CC_PERIOD)) u_cc (
    .i_clk       (i_c2c_phy_clk),
    .i_rst       (i_rst),
    .i_inhibit   (r_state == ST_RESET_TX),
    .i_tx_valid  (w_tx_valid_eff),
    .i_tx_data   (i_c2c_tx_tdata),
    .o_insert_cc (w_insert_cc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer - 1'b1;
    case (r_state)
      ST_RESET_TX: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_HOLDOFF;
          w_timer_nxt = T_HOLD;
        end
      end
      ST_HOLDOFF: begin
        if (i_link_reset_req) begin
          w_state_nxt = ST_RESET_TX;
          w_timer_nxt = T_LRST;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_WAIT_ALIGN;
          w_timer_nxt = T_TOUT;
        end
      end
      ST_WAIT_ALIGN: begin
        if (i_link_reset_req) begin
          w_state_nxt = ST_RESET_TX;
          w_timer_nxt = T_LRST;
        end else if (w_align_hit) begin
          w_state_nxt = ST_UP;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_RESET_TX;
          w_timer_nxt = T_LRST;
        end
      end
      ST_UP: begin
        w_timer_nxt = r_timer;
        if (i_link_reset_req || !i_rx_aligned) begin
          w_state_nxt = ST_RESET_TX;
          w_timer_nxt = T_LRST;
        end
      end
      default: begin
        w_state_nxt = ST_RESET_TX;
        w_timer_nxt = T_LRST;
      end
    endcase
  end

  always_comb begin
    w_tx_d = ZERO_D;
    w_tx_k = ZERO_K;
    if (r_state == ST_RESET_TX) begin
      w_tx_d = LRST_D;
      w_tx_k = LRST_K;
    end else if (w_insert_cc) begin
      w_tx_d = CLKC_D;
      w_tx_k = CLKC_K;
    end else if (w_tx_valid_eff) begin
      w_tx_d = i_c2c_tx_tdata;
    end
  end

  always_comb begin
    w_rx_special = ((i_mgt_rx_data == CLKC_D) && (i_mgt_rx_k == CLKC_K)) ||
                   ((i_mgt_rx_data == LRST_D) && (i_mgt_rx_k == LRST_K));
    w_rx_d = w_rx_special ? ZERO_D : i_mgt_rx_data;
    w_rx_v = !w_rx_special && i_rx_aligned &&
             ((r_state == ST_WAIT_ALIGN) || (r_state == ST_UP));
  end

  always_ff @(posedge i_c2c_phy_clk) begin
    if (i_rst) begin
      r_state        <= ST_RESET_TX;
      r_timer        <= T_LRST;
      r_align_cnt    <= '0;
      o_lrst_count   <= '0;
      o_link_up      <= 1'b0;
      o_mgt_tx_data  <= '0;
      o_mgt_tx_k     <= '0;
      o_c2c_rx_data  <= '0;
      o_c2c_rx_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_align_cnt <= ((r_state == ST_WAIT_ALIGN) && i_rx_aligned) ? r_align_cnt + 16'd1 : 16'd0;
      // timer is always loaded with T_LRST on entry, so this marks the first cycle
      if ((r_state == ST_RESET_TX) && (r_timer == T_LRST) && (o_lrst_count != 16'hFFFF))
        o_lrst_count <= o_lrst_count + 16'd1;
      o_link_up      <= (w_state_nxt == ST_UP);
      o_mgt_tx_data  <= w_tx_d;
      o_mgt_tx_k     <= w_tx_k;
      o_c2c_rx_data  <= w_rx_d;
      o_c2c_rx_valid <= w_rx_v;
    end
  end

endmodule

// File: tb/tb_c2c_master_adapter.sv
module tb_c2c_master_adapter;

  localparam int P_CC   = 700;
  localparam int P_LRST = 16;
  localparam int P_HO   = 1200;
  localparam int P_AS   = 256;
  localparam int P_TO   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_tdata;
  logic        tx_tvalid;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic [31:0] mgt_rx_data;
  logic [3:0]  mgt_rx_k;
  logic        rx_aligned;
  logic [31:0] mgt_tx_data;
  logic [3:0]  mgt_tx_k;
  logic        link_reset_req;
  logic        link_up;
  logic [15:0] lrst_count;

  always #5 clk = ~clk;

  c2c_master_adapter #(
    .CC_PERIOD(P_CC), .LRST_LEN(P_LRST), .HOLDOFF_LEN(P_HO),
    .ALIGN_STABLE(P_AS), .ALIGN_TIMEOUT(P_TO)
  ) dut (
    .i_c2c_phy_clk   (clk),
    .i_rst           (rst),
    .i_c2c_tx_tdata  (tx_tdata),
    .i_c2c_tx_tvalid (tx_tvalid),
    .o_c2c_rx_data   (rx_data),
    .o_c2c_rx_valid  (rx_valid),
    .i_mgt_rx_data   (mgt_rx_data),
    .i_mgt_rx_k      (mgt_rx_k),
    .i_rx_aligned    (rx_aligned),
    .o_mgt_tx_data   (mgt_tx_data),
    .o_mgt_tx_k      (mgt_tx_k),
    .i_link_reset_req(link_reset_req),
    .o_link_up       (link_up),
    .o_lrst_count    (lrst_count)
  );

  typedef struct packed {
    logic [31:0] tx_d;
    logic [3:0]  tx_k;
    logic [31:0] rx_d;
    logic        rx_v;
    logic        up;
    logic [15:0] lrst;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err    = 0;

  // reference model: phase 0=link reset, 1=holdoff, 2=awaiting alignment, 3=up
  int m_phase = 0;
  int m_age   = 0;
  int m_run   = 0;
  int m_n     = 0;
  bit m_pend  = 0;
  int m_lrst  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // txm: 0 random, 1 hold DEADBEEF, 2 hold 001011BC, 3 idle
  task automatic cyc(input bit r, input bit req, input bit aln, input int txm);
    exp_t        e;
    logic        v;
    logic [31:0] d, rd;
    logic [3:0]  rk;
    bit          expiry, special;
    @(negedge clk);
    case (txm)
      0: begin
        v = 1'($urandom % 2);
        case ($urandom % 5)
          0: d = 32'h0010_11BC;
          1: d = 32'h0010_11FC;
          2: d = 32'h0;
          default: d = $urandom;
        endcase
      end
      1: begin v = 1'b1; d = 32'hDEAD_BEEF; end
      2: begin v = 1'b1; d = 32'h0010_11BC; end
      default: begin v = 1'b0; d = $urandom; end
    endcase
    case ($urandom % 8)
      0: begin rd = 32'h0000_50BC; rk = 4'b0001; end
      1: begin rd = 32'hFCFC_FCFC; rk = 4'b1111; end
      2: begin rd = 32'h0000_50BC; rk = 4'b0011; end
      default: begin rd = $urandom; rk = 4'($urandom); end
    endcase
    rst = r; link_reset_req = req; rx_aligned = aln;
    tx_tvalid = v; tx_tdata = d; mgt_rx_data = rd; mgt_rx_k = rk;

    e = '0;
    if (r) begin
      m_phase = 0; m_age = 0; m_run = 0; m_n = 0; m_pend = 0; m_lrst = 0;
    end else begin
      if (m_phase == 0 && m_age == 0 && m_lrst < 65535) m_lrst++;
      expiry = ((m_n % P_CC) == P_CC - 1);
      m_n++;
      if (m_phase == 0) begin
        e.tx_d = 32'hFCFC_FCFC; e.tx_k = 4'hF;
      end else begin
        bit vv;
        vv = v && (m_phase != 1);
        if (m_pend && (!vv || d == 32'h0010_11BC || d == 32'h0010_11FC || d == 0)) begin
          e.tx_d = 32'h0000_50BC; e.tx_k = 4'b0001; m_pend = 0;
        end else if (vv) begin
          e.tx_d = d;
        end
      end
      if (expiry) m_pend = 1;
      special = (rd == 32'h0000_50BC && rk == 4'b0001) || (rd == 32'hFCFC_FCFC && rk == 4'hF);
      e.rx_d = special ? 32'h0 : rd;
      e.rx_v = !special && aln && (m_phase >= 2);
      case (m_phase)
        0: if (m_age == P_LRST - 1) begin m_phase = 1; m_age = 0; end else m_age++;
        1: if (req) begin m_phase = 0; m_age = 0; end
           else if (m_age == P_HO - 1) begin m_phase = 2; m_age = 0; m_run = 0; end
           else m_age++;
        2: begin
          m_run = aln ? m_run + 1 : 0;
          if (req) begin m_phase = 0; m_age = 0; end
          else if (m_run == P_AS) m_phase = 3;
          else if (m_age == P_TO - 1) begin m_phase = 0; m_age = 0; end
          else m_age++;
        end
        default: if (req || !aln) begin m_phase = 0; m_age = 0; end
      endcase
      e.up   = (m_phase == 3);
      e.lrst = 16'(m_lrst);
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mgt_tx_data",  mgt_tx_data,          e.tx_d);
        chk("mgt_tx_k",     {28'd0, mgt_tx_k},    {28'd0, e.tx_k});
        chk("c2c_rx_data",  rx_data,              e.rx_d);
        chk("c2c_rx_valid", {31'd0, rx_valid},    {31'd0, e.rx_v});
        chk("link_up",      {31'd0, link_up},     {31'd0, e.up});
        chk("lrst_count",   {16'd0, lrst_count},  {16'd0, e.lrst});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    n_err++;
    $display("FAIL watchdog: got no end of stimulus, required finish before t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : driver
    rst = 1'b1; link_reset_req = 1'b0; rx_aligned = 1'b0;
    tx_tvalid = 1'b0; tx_tdata = '0; mgt_rx_data = '0; mgt_rx_k = '0;
    repeat (3) cyc(1, 0, 0, 0);
    // bring-up with alignment appearing exactly at WAIT_ALIGN entry
    repeat (P_LRST + P_HO) cyc(0, 0, 0, 0);
    repeat (300) cyc(0, 0, 1, 0);
    repeat (1000) cyc(0, 0, 1, 0);
    // CC held off by non-interruptible data, then released by a filler word
    repeat (P_CC + 50) cyc(0, 0, 1, 1);
    repeat (6) cyc(0, 0, 1, 2);
    repeat (6) cyc(0, 0, 1, 3);
    // single-cycle alignment loss in UP, then recover
    cyc(0, 0, 0, 0);
    repeat (1700) cyc(0, 0, 1, 0);
    // software request in UP, then flaky alignment with rare requests
    cyc(0, 1, 1, 0);
    repeat (3000) cyc(0, ($urandom % 1500) == 0, ($urandom % 512) != 0, 0);
    // no alignment ever: timeout retries, requests during RESET_TX ignored
    repeat (2 * (P_LRST + P_HO + P_TO) + 100)
      cyc(0, (m_phase == 0) && (($urandom % 3) == 0), 0, 0);
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
